// File: rtl/gyro_txfifo_pkg.sv
// Shared types and default widths for the gyro transmit stream buffer.
package gyro_txfifo_pkg;

   localparam int unsigned TXFIFO_STRM_DW = 32;
   localparam int unsigned TXFIFO_STRM_UW = 4;
   localparam int unsigned TXFIFO_STRM_SW = 4;
   localparam int unsigned TXFIFO_DEPTH   = 16;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FLUSH_WAIT = 2'd1,
      CLEAR      = 2'd2
   } txfifo_state_e;

   typedef struct packed {
      logic                      tlast;
      logic [TXFIFO_STRM_SW-1:0] tstrb;
      logic [TXFIFO_STRM_UW-1:0] tuser;
      logic [TXFIFO_STRM_DW-1:0] tdata;
   } txfifo_entry_t;

endpackage

// File: rtl/gyro_txfifo_mem.sv
// DEPTH x W register store: one synchronous write port, one asynchronous read port.
module gyro_txfifo_mem #(
   parameter int unsigned W     = 41,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Cleared on reset so the fall-through output reads zero from an empty store.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gyro_txfifo.sv
// Transmit stream buffer with optional store-and-forward, flush control and
// level / packet-count status.
module gyro_txfifo
   import gyro_txfifo_pkg::*;
#(
   parameter int unsigned DW    = TXFIFO_STRM_DW,
   parameter int unsigned UW    = TXFIFO_STRM_UW,
   parameter int unsigned SW    = TXFIFO_STRM_SW,
   parameter int unsigned DEPTH = TXFIFO_DEPTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       s_tvalid_i,
   output logic                       s_tready_o,
   input  logic [DW-1:0]              s_tdata_i,
   input  logic [UW-1:0]              s_tuser_i,
   input  logic [SW-1:0]              s_tstrb_i,
   input  logic                       s_tlast_i,
   output logic                       m_tvalid_o,
   input  logic                       m_tready_i,
   output logic [DW-1:0]              m_tdata_o,
   output logic [UW-1:0]              m_tuser_o,
   output logic [SW-1:0]              m_tstrb_o,
   output logic                       m_tlast_o,
   input  logic                       enable_i,
   input  logic                       pkt_mode_i,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [$clog2(DEPTH):0]     pkt_cnt_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       flush_busy_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned EW = 1 + SW + UW + DW;

   typedef struct packed {
      logic          tlast;
      logic [SW-1:0] tstrb;
      logic [UW-1:0] tuser;
      logic [DW-1:0] tdata;
   } entry_t;

   txfifo_state_e state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d, pkt_cnt_q, pkt_cnt_d;
   logic          full_q, full_d, empty_q, empty_d, ct_q, ct_d;
   logic          run_c, clear_c, release_c, s_tready_c, m_tvalid_c, push_c, pop_c;
   entry_t        wr_entry, rd_entry;

   assign wr_entry = '{tlast: s_tlast_i, tstrb: s_tstrb_i, tuser: s_tuser_i, tdata: s_tdata_i};
   assign push_c   = s_tvalid_i & s_tready_c;
   assign pop_c    = m_tvalid_c & m_tready_i;

   gyro_txfifo_mem #(
      .W     (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (push_c),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Flush waits for any presented beat to complete so the stream never breaks mid-beat.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:        if (flush_i) state_d = FLUSH_WAIT;
         FLUSH_WAIT: if (!m_tvalid_c || pop_c) state_d = CLEAR;
         CLEAR:      state_d = RUN;
         default:    state_d = RUN;
      endcase
   end

   always_comb begin
      run_c      = (state_q == RUN);
      clear_c    = (state_q == CLEAR);
      release_c  = !pkt_mode_i || (pkt_cnt_q != '0) || ct_q;
      s_tready_c = !rst_i && enable_i && !full_q && run_c;
      m_tvalid_c = !empty_q && release_c && !clear_c;
   end

   // Cut-through override keeps an oversize packet from deadlocking a full store.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + AW'(push_c);
      rd_ptr_d  = rd_ptr_q + AW'(pop_c);
      level_d   = level_q + LW'(push_c) - LW'(pop_c);
      pkt_cnt_d = pkt_cnt_q + LW'(push_c & s_tlast_i) - LW'(pop_c & rd_entry.tlast);
      ct_d      = ct_q;
      if (pop_c && rd_entry.tlast) ct_d = 1'b0;
      if (pkt_mode_i && full_q && (pkt_cnt_q == '0)) ct_d = 1'b1;
      if (clear_c) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         pkt_cnt_d = '0;
         ct_d      = 1'b0;
      end
      full_d  = (level_d == LW'(DEPTH));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         pkt_cnt_q <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ct_q      <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         pkt_cnt_q <= pkt_cnt_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         ct_q      <= ct_d;
      end
   end

   assign s_tready_o   = s_tready_c;
   assign m_tvalid_o   = m_tvalid_c;
   assign m_tdata_o    = rd_entry.tdata;
   assign m_tuser_o    = rd_entry.tuser;
   assign m_tstrb_o    = rd_entry.tstrb;
   assign m_tlast_o    = rd_entry.tlast;
   assign level_o      = level_q;
   assign pkt_cnt_o    = pkt_cnt_q;
   assign full_o       = full_q;
   assign empty_o      = empty_q;
   assign flush_busy_o = !run_c;

endmodule

// File: tb/tb_gyro_txfifo.sv
// Scoreboard bench for gyro_txfifo: a queue-based reference of the store is
// compared every cycle against handshakes, data and status outputs.
module tb_gyro_txfifo;
   import gyro_txfifo_pkg::*;

   localparam int DEPTH = 16;
   localparam int P_RUN = 0, P_WAIT = 1, P_CLEAR = 2;

   logic        clk = 1'b0, rst = 1'b1;
   logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [31:0] s_tdata = '0, m_tdata;
   logic [3:0]  s_tuser = '0, s_tstrb = '0, m_tuser, m_tstrb;
   logic        m_tvalid, m_tready = 1'b0, m_tlast;
   logic        enable = 1'b1, pkt_mode = 1'b0, flush = 1'b0;
   logic [4:0]  level, pkt_cnt;
   logic        full, empty, flush_busy;

   int total = 0, bad = 0;
   int rdy_mode = 1, en_mode = 1;

   txfifo_entry_t exp_q[$];
   int            phase = P_RUN, old_phase, sz, np;
   bit            ct_m = 1'b0, e_sr, rel, e_mv, hs_push, hs_pop;
   txfifo_entry_t got, beat_in, f;

   gyro_txfifo dut (
      .clk_i(clk), .rst_i(rst),
      .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
      .s_tuser_i(s_tuser), .s_tstrb_i(s_tstrb), .s_tlast_i(s_tlast),
      .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata),
      .m_tuser_o(m_tuser), .m_tstrb_o(m_tstrb), .m_tlast_o(m_tlast),
      .enable_i(enable), .pkt_mode_i(pkt_mode), .flush_i(flush),
      .level_o(level), .pkt_cnt_o(pkt_cnt), .full_o(full), .empty_o(empty),
      .flush_busy_o(flush_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int count_pkts();
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].tlast) n++;
      return n;
   endfunction

   // Scoreboard monitor: samples 1 time unit before each rising edge.
   initial begin : monitor
      forever begin
         @(negedge clk); #4;
         if (rst) begin
            chk("rst_s_tready", s_tready, 0);
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_m_beat", {m_tlast, m_tstrb, m_tuser, m_tdata}, 0);
            chk("rst_level", level, 0);
            chk("rst_pkt_cnt", pkt_cnt, 0);
            chk("rst_full", full, 0);
            chk("rst_empty", empty, 1);
            chk("rst_flush_busy", flush_busy, 0);
            exp_q.delete();
            ct_m  = 1'b0;
            phase = P_RUN;
         end else begin
            sz   = exp_q.size();
            np   = count_pkts();
            e_sr = enable && (sz < DEPTH) && (phase == P_RUN);
            rel  = !pkt_mode || (np > 0) || ct_m;
            e_mv = (sz > 0) && rel && (phase != P_CLEAR);
            chk("level", level, 64'(sz));
            chk("pkt_cnt", pkt_cnt, 64'(np));
            chk("full", full, 64'(sz == DEPTH));
            chk("empty", empty, 64'(sz == 0));
            chk("flush_busy", flush_busy, 64'(phase != P_RUN));
            chk("s_tready", s_tready, 64'(e_sr));
            chk("m_tvalid", m_tvalid, 64'(e_mv));
            got.tdata = m_tdata; got.tuser = m_tuser; got.tstrb = m_tstrb; got.tlast = m_tlast;
            if (e_mv && m_tvalid) chk("m_beat", got, exp_q[0]);

            hs_push = s_tvalid && s_tready;
            hs_pop  = m_tvalid && m_tready;
            old_phase = phase;
            case (phase)
               P_RUN:   if (flush) phase = P_WAIT;
               P_WAIT:  if (!e_mv || hs_pop) phase = P_CLEAR;
               default: phase = P_RUN;
            endcase
            if (old_phase == P_CLEAR) begin
               exp_q.delete();
               ct_m = 1'b0;
            end else begin
               if (hs_pop && exp_q.size() > 0) begin
                  f = exp_q.pop_front();
                  if (f.tlast) ct_m = 1'b0;
               end
               if (hs_push) begin
                  beat_in.tdata = s_tdata; beat_in.tuser = s_tuser;
                  beat_in.tstrb = s_tstrb; beat_in.tlast = s_tlast;
                  exp_q.push_back(beat_in);
               end
               if (pkt_mode && sz == DEPTH && np == 0) ct_m = 1'b1;
            end
         end
      end
   end

   // Downstream ready and upstream enable generators.
   initial begin : pacing
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(0, 3) != 0);
         endcase
         enable = (en_mode == 1) ? 1'b1 : ($urandom_range(0, 9) != 0);
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      bit acc = 1'b0;
      s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
      s_tuser = 4'($urandom); s_tstrb = 4'($urandom);
      for (int n = 0; n < 1000 && !acc; n++) begin
         #4; acc = s_tready;
         @(negedge clk);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("send_accepted", acc, 1);
   endtask

   task automatic wait_drained();
      bit ok = 1'b0;
      for (int n = 0; n < 2000 && !ok; n++) begin
         #4; ok = empty && !flush_busy;
         @(negedge clk);
      end
      chk("drain_done", ok, 1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin : stim
      idle(3);
      rst = 1'b0;
      idle(1);

      // Back-to-back single beats, pass-through mode.
      send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b1);
      idle(3);

      // Fill to full, refused extra beat, then drain across the pointer wrap.
      rdy_mode = 0; idle(1);
      for (int i = 0; i < DEPTH; i++) send(32'h100 + 32'(i), 1'(i == DEPTH - 1));
      s_tvalid = 1'b1; s_tdata = 32'hDEAD; idle(3); s_tvalid = 1'b0;
      rdy_mode = 1;
      wait_drained();

      // Store-and-forward: packet held until tlast is stored.
      pkt_mode = 1'b1; idle(1);
      send(32'hA1, 1'b0); send(32'hA2, 1'b0); idle(5); send(32'hA3, 1'b1);
      wait_drained();

      // Oversize packet forces cut-through.
      for (int i = 0; i < 20; i++) send(32'hB00 + 32'(i), 1'(i == 19));
      wait_drained();
      pkt_mode = 1'b0; idle(1);

      // Flush while a beat is presented and stalled.
      rdy_mode = 0; idle(1);
      send(32'hC1, 1'b0); send(32'hC2, 1'b0); send(32'hC3, 1'b1);
      pulse_flush();
      idle(3);
      rdy_mode = 1;
      wait_drained();

      // Reset in the middle of traffic.
      rdy_mode = 0; idle(1);
      for (int i = 0; i < 5; i++) send(32'hD0 + 32'(i), 1'b0);
      rst = 1'b1; idle(2); rst = 1'b0;
      rdy_mode = 1; idle(1);
      send(32'hE1, 1'b1);
      wait_drained();

      // Randomized packets, backpressure, enable gaps and occasional flushes.
      for (int seg = 0; seg < 6; seg++) begin
         pkt_mode = 1'(seg % 2);
         rdy_mode = 2; en_mode = 2;
         for (int p = 0; p < 8; p++) begin
            int len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) send($urandom, 1'(b == len - 1));
            if ($urandom_range(0, 9) == 0) pulse_flush();
         end
         en_mode = 1; rdy_mode = 1;
         wait_drained();
         idle(2);
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
